keypad_entry: RTL and testbench

Keypad front end for the door lock. It debounces a 4×4 keypad's key strobe and accumulates decimal digits into a 17-bit code. It drives the password checker's `in_password`, `change_password`, `rsbuttonState` and `e_buttonState` inputs, so it is the sending end of the password-check interface. A mode key selects a two-phase change-password sequence; the enter key issues a clean, setup-aligned enter pulse.

---
 rtl/keypad_entry.sv | 222 ++++++++++++++++++++++
 tb/tb_keypad_entry.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/keypad_entry.sv
// Keypad front end: synchronizes and debounces the key strobe, accumulates decimal
// digits and issues a setup-aligned enter pulse. Optional idle timeout: KEYPAD_TIMEOUT_EN.
module keypad_entry #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int MAX_DIGITS      = 5,
  parameter int ENTER_WIDTH     = 2,
  parameter int TIMEOUT_CYCLES  = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        key_down,
  input  logic [3:0]  key_code,
  output logic [16:0] in_password,
  output logic [16:0] change_password,
  output logic        rsbutton,
  output logic        e_button,
  output logic        change_mode,
  output logic [2:0]  digit_count,
  output logic        busy
);

  localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int SW  = $clog2(ENTER_WIDTH + 1);

  localparam logic [3:0] KEY_CLR  = 4'd10;
  localparam logic [3:0] KEY_ENT  = 4'd11;
  localparam logic [3:0] KEY_MODE = 4'd12;

  typedef enum logic [1:0] {ENTER_PW, ENTER_NEW, SETUP, STROBE} state_t;

  // ---------------- input conditioning ----------------
  logic [1:0]     kd_sync;
  logic [3:0]     kc_s1, kc_s2;
  logic           db_level;
  logic [DBW-1:0] db_cnt;
  logic           press;
  logic [3:0]     press_code;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kd_sync <= '0;
      kc_s1   <= '0;
      kc_s2   <= '0;
    end else begin
      kd_sync <= {kd_sync[0], key_down};
      kc_s1   <= key_code;
      kc_s2   <= kc_s1;
    end
  end

  // A differing sample that reverts before the count completes resets the count,
  // so only a level held for DEBOUNCE_CYCLES samples is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_level   <= 1'b0;
      db_cnt     <= '0;
      press      <= 1'b0;
      press_code <= '0;
    end else begin
      press <= 1'b0;
      if (kd_sync[1] == db_level) begin
        db_cnt <= '0;
      end else if (db_cnt == DBW'(DEBOUNCE_CYCLES - 1)) begin
        db_level <= kd_sync[1];
        db_cnt   <= '0;
        if (kd_sync[1]) begin
          press      <= 1'b1;
          press_code <= kc_s2;
        end
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  // ---------------- entry FSM ----------------
  state_t        state, state_n;
  logic [16:0]   acc, acc_n;
  logic [2:0]    dcnt, dcnt_n;
  logic          cm, cm_n;
  logic [16:0]   inpw, inpw_n, chpw, chpw_n;
  logic          rs, rs_n, eb, eb_n;
  logic [SW-1:0] scnt, scnt_n;
  logic          is_digit, can_acc;

`ifdef KEYPAD_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] idle, idle_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) idle <= '0;
    else        idle <= idle_n;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ENTER_PW;
      acc   <= '0;
      dcnt  <= '0;
      cm    <= 1'b0;
      inpw  <= '0;
      chpw  <= '0;
      rs    <= 1'b0;
      eb    <= 1'b0;
      scnt  <= '0;
    end else begin
      state <= state_n;
      acc   <= acc_n;
      dcnt  <= dcnt_n;
      cm    <= cm_n;
      inpw  <= inpw_n;
      chpw  <= chpw_n;
      rs    <= rs_n;
      eb    <= eb_n;
      scnt  <= scnt_n;
    end
  end

  assign is_digit = (press_code <= 4'd9);
  assign can_acc  = (int'(dcnt) < MAX_DIGITS);

  always_comb begin
    state_n = state;
    acc_n   = acc;
    dcnt_n  = dcnt;
    cm_n    = cm;
    inpw_n  = inpw;
    chpw_n  = chpw;
    rs_n    = rs;
    eb_n    = eb;
    scnt_n  = scnt;
`ifdef KEYPAD_TIMEOUT_EN
    idle_n  = '0;
`endif
    case (state)
      ENTER_PW, ENTER_NEW: begin
        if (press) begin
          if (is_digit) begin
            if (can_acc) begin
              acc_n  = acc * 17'd10 + {13'd0, press_code};
              dcnt_n = dcnt + 3'd1;
            end
          end else begin
            case (press_code)
              KEY_CLR: begin
                acc_n  = '0;
                dcnt_n = '0;
              end
              KEY_MODE: begin
                acc_n  = '0;
                dcnt_n = '0;
                if (state == ENTER_PW) begin
                  cm_n = ~cm;
                end else begin
                  cm_n    = 1'b0;
                  state_n = ENTER_PW;
                end
              end
              KEY_ENT: begin
                if (state == ENTER_NEW) begin
                  chpw_n  = acc;
                  rs_n    = 1'b1;
                  state_n = SETUP;
                end else if (cm) begin
                  inpw_n  = acc;
                  acc_n   = '0;
                  dcnt_n  = '0;
                  state_n = ENTER_NEW;
                end else begin
                  inpw_n  = acc;
                  rs_n    = 1'b0;
                  state_n = SETUP;
                end
              end
              default: ;
            endcase
          end
        end
`ifdef KEYPAD_TIMEOUT_EN
        // Abandoned partial entries are wiped; the registered code is left alone.
        else if (dcnt != 3'd0 || cm) begin
          if (idle == TW'(TIMEOUT_CYCLES - 1)) begin
            acc_n   = '0;
            dcnt_n  = '0;
            cm_n    = 1'b0;
            state_n = ENTER_PW;
          end else begin
            idle_n = idle + 1'b1;
          end
        end
`endif
      end
      SETUP: begin
        eb_n    = 1'b1;
        scnt_n  = '0;
        state_n = STROBE;
      end
      STROBE: begin
        if (scnt == SW'(ENTER_WIDTH - 1)) begin
          eb_n    = 1'b0;
          acc_n   = '0;
          dcnt_n  = '0;
          cm_n    = 1'b0;
          state_n = ENTER_PW;
        end else begin
          scnt_n = scnt + 1'b1;
        end
      end
      default: state_n = ENTER_PW;
    endcase
  end

  assign in_password     = inpw;
  assign change_password = chpw;
  assign rsbutton        = rs;
  assign e_button        = eb;
  assign change_mode     = cm;
  assign digit_count     = dcnt;
  assign busy            = (state == SETUP) || (state == STROBE);

endmodule

// File: tb/tb_keypad_entry.sv
// Directed bench for keypad_entry: digit entry, saturation, change sequence,
// bounce rejection, ignored codes, idle behaviour and reset during the strobe.
module tb_keypad_entry;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        key_down = 1'b0;
  logic [3:0]  key_code = 4'd0;
  logic [16:0] in_password, change_password;
  logic        rsbutton, e_button, change_mode, busy;
  logic [2:0]  digit_count;

  int errors = 0;
  int checks = 0;

  keypad_entry #(.DEBOUNCE_CYCLES(4), .MAX_DIGITS(5), .ENTER_WIDTH(2), .TIMEOUT_CYCLES(50)) dut (
    .clk(clk), .rst_n(rst_n), .key_down(key_down), .key_code(key_code),
    .in_password(in_password), .change_password(change_password), .rsbutton(rsbutton),
    .e_button(e_button), .change_mode(change_mode), .digit_count(digit_count), .busy(busy)
  );

  always #5 clk = ~clk;

  // enter-pulse monitor
  int   pulses = 0, cur_w = 0, last_w = 0, setup_ok = 0;
  logic prev_eb = 1'b0, prev_busy = 1'b0, prev2_busy = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      cur_w = 0; prev_eb = 1'b0; prev_busy = 1'b0; prev2_busy = 1'b0;
    end else begin
      if (e_button) begin
        if (!prev_eb) begin
          pulses++;
          setup_ok = (prev_busy && !prev2_busy) ? 1 : 0;
        end
        cur_w++;
      end else if (prev_eb) begin
        last_w = cur_w;
        cur_w  = 0;
      end
      prev_eb    = e_button;
      prev2_busy = prev_busy;
      prev_busy  = busy;
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic key(input logic [3:0] c);
    key_code = c;
    key_down = 1'b1;
    cyc(10);
    key_down = 1'b0;
    cyc(10);
  endtask

  task automatic submit(input string tag, input int pw, input int rs);
    int p0;
    p0 = pulses;
    key(4'd11);
    chk({tag, "_pw"}, in_password, pw);
    chk({tag, "_rs"}, rsbutton, rs);
    chk({tag, "_pulses"}, pulses - p0, 1);
    chk({tag, "_width"}, last_w, 2);
    chk({tag, "_setup"}, setup_ok, 1);
    chk({tag, "_idle"}, {busy, e_button, change_mode, digit_count}, 0);
  endtask

  initial begin
    int p0;
    cyc(3);
    chk("rst_outs", {in_password, change_password, rsbutton, e_button, change_mode, digit_count, busy}, 0);
    rst_n = 1'b1;
    cyc(2);

    // plain unlock
    key(4); key(5); key(6); key(7); key(5);
    chk("t1_count", digit_count, 5);
    submit("t1", 45675, 0);

    // saturation at MAX_DIGITS
    for (int d = 1; d <= 7; d++) key(4'(d));
    chk("t2_count", digit_count, 5);
    submit("t2", 12345, 0);

    // change-password sequence
    key(12);
    chk("t3_mode", change_mode, 1);
    key(1); key(1);
    p0 = pulses;
    key(11);
    chk("t3_nopulse", pulses - p0, 0);
    chk("t3_mode_hold", change_mode, 1);
    chk("t3_pw1", in_password, 11);
    chk("t3_cnt_clr", digit_count, 0);
    key(2); key(2);
    submit("t3", 11, 1);
    chk("t3_chpw", change_password, 22);

    // bouncing strobe yields one digit
    key_code = 4'd9;
    for (int i = 0; i < 6; i++) begin
      key_down = (i % 2 == 0);
      cyc(1);
    end
    key_down = 1'b1;
    cyc(12);
    key_down = 1'b0;
    cyc(10);
    chk("t4_count", digit_count, 1);
    submit("t4", 9, 0);

    // clear, ignored code, empty submit
    key(5); key(13); key(15);
    chk("t5_ignored", digit_count, 1);
    key(10);
    chk("t5_clr", digit_count, 0);
    submit("t5", 0, 0);

    // idle partial entry
    key(3); key(8);
    cyc(60);
`ifdef KEYPAD_TIMEOUT_EN
    chk("t6_cnt", digit_count, 0);
    submit("t6", 0, 0);
`else
    chk("t6_cnt", digit_count, 2);
    submit("t6", 38, 0);
`endif

    // reset in the middle of the strobe
    key(12); key(1); key(11); key(2);
    key_code = 4'd11;
    key_down = 1'b1;
    for (int i = 0; i < 30 && !e_button; i++) cyc(1);
    chk("t7_strobe_seen", e_button, 1);
    rst_n = 1'b0;
    #1;
    chk("t7_eb_async", e_button, 0);
    chk("t7_outs", {in_password, change_password, rsbutton, change_mode, digit_count, busy}, 0);
    key_down = 1'b0;
    cyc(3);
    rst_n = 1'b1;
    cyc(2);
    key(7);
    submit("t7_after", 7, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
